mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch requester (i-port, read-only) and the memory-stage requester (d-port, read/write).
- Sits between the fetch/memory stages and the external memory controller.
- Sequences one transaction at a time with a registered grant FSM.
- Data-priority with a starvation guard for fetch, plus a watchdog timeout with a sticky error flag.

Parameters:
- DATA_W, 32, width of address/data words (matches rvga_word).
- D_STREAK_MAX, 4, max consecutive d-port grants while the i-port waits; next grant forced to i-port.
- TIMEOUT_CYCLES, 1024, cycles in a SERVE state without pmem_resp before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- iddr_addr  in  DATA_W  fetch address.
- iddr_read  in  1  fetch request (level, held until iddr_resp).
- iddr_rdata  out  DATA_W  fetch read data, valid with iddr_resp.
- iddr_resp  out  1  single-cycle completion pulse to i-port.
- dddr_addr  in  DATA_W  data address.
- dddr_read  in  1  data read request (level, held until dddr_resp).
- dddr_write  in  1  data write request (level, held until dddr_resp).
- dddr_wdata  in  DATA_W  write data.
- dddr_rdata  out  DATA_W  data read data, valid with dddr_resp.
- dddr_resp  out  1  single-cycle completion pulse to d-port.
- pmem_addr  out  DATA_W  physical address (registered).
- pmem_read  out  1  physical read strobe (registered, held until pmem_resp).
- pmem_write  out  1  physical write strobe (registered, held until pmem_resp).
- pmem_wdata  out  DATA_W  physical write data (registered).
- pmem_rdata  in  DATA_W  physical read data.
- pmem_resp  in  1  physical completion pulse.
- arb_err  out  1  sticky watchdog-timeout flag.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE.
- Reset values: pmem_addr/pmem_wdata=0, pmem_read=pmem_write=0, streak=0, wdog=0, arb_err=0.
- A reset mid-transaction abandons the transaction; no resp is issued.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE, d_req=(dddr_read|dddr_write), i_req=iddr_read:
  - d_req and (!i_req or streak<D_STREAK_MAX): latch dddr_addr, dddr_wdata, dddr_read, dddr_write into pmem regs; go to SERVE_D. If i_req, streak++ (saturating); else streak=0.
  - else if i_req: latch iddr_addr, pmem_read=1, pmem_write=0; go to SERVE_I; streak=0.
  - else stay in IDLE.
- dddr_read and dddr_write both high is illegal. Arbiter then asserts both pmem strobes unchanged (no masking); the bench must flag it.
- SERVE_x:
  - pmem strobes held constant.
  - On pmem_resp: x_resp=1 combinationally in the same cycle; x_rdata=pmem_rdata; strobes clear; return to IDLE next cycle.
  - One IDLE bubble between transactions is mandatory.
- Latency: request seen at edge N; pmem strobe high from N+1; resp to requester in the same cycle as pmem_resp.
- Non-granted resp is 0. Both rdata outputs equal pmem_rdata when not responding, and are don't-care.
- Requester dropping its request during SERVE: the physical transaction still completes; the resp pulse is still generated.
- Watchdog:
  - wdog counts cycles in SERVE with no pmem_resp.
  - When wdog reaches TIMEOUT_CYCLES-1 without resp: set arb_err=1 (sticky until reset); pulse granted x_resp with x_rdata=0; clear strobes; go to IDLE.
  - pmem_resp in the same cycle as timeout counts as normal completion; arb_err stays unchanged.
- pmem_resp while IDLE is ignored.
- Simultaneous i/d requests with streak below max: d-port wins.

Test Plan:
- Lone i-port read of 0x0000_0100, pmem_resp 3 cycles later with rdata 0xDEADBEEF -> pmem_read high 3 cycles; iddr_resp 1 cycle with iddr_rdata=0xDEADBEEF; dddr_resp stays 0.
- d-port write 0x40 <- 0x1234_5678 alongside i-port read -> d granted first with pmem_write=1, pmem_wdata=0x12345678; one IDLE bubble; then i granted.
- d-port requests back-to-back continuously while i_req held, D_STREAK_MAX=4 -> 4 d grants, then 5th grant to i-port, then d resumes.
- TIMEOUT_CYCLES=8, pmem_resp never asserted on a d read -> dddr_resp pulses 8 cycles after strobe rises with rdata=0; arb_err=1 and stays 1; the next request is still served.
- rst_n low during SERVE_D -> next cycle pmem_read/pmem_write=0, no dddr_resp, arb_err=0, state IDLE.
- pmem_resp pulse in IDLE with no requests -> no resp outputs; state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch (read-only) and the data stage (read/write).
// Data port wins ties, but fetch is forced in after D_STREAK_MAX data grants; a watchdog aborts stuck transfers.
module mem_arbiter #(
    parameter int DATA_W         = 32,
    parameter int D_STREAK_MAX   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [DATA_W-1:0] iddr_addr,
    input  logic              iddr_read,
    output logic [DATA_W-1:0] iddr_rdata,
    output logic              iddr_resp,

    input  logic [DATA_W-1:0] dddr_addr,
    input  logic              dddr_read,
    input  logic              dddr_write,
    input  logic [DATA_W-1:0] dddr_wdata,
    output logic [DATA_W-1:0] dddr_rdata,
    output logic              dddr_resp,

    output logic [DATA_W-1:0] pmem_addr,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              arb_err
);

    localparam int STREAK_W = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
    localparam int WDOG_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_STREAK_MAX);
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit                  WDOG_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                read_q, read_d;
    logic                write_q, write_d;

    logic i_req, d_req, serving, timeout, done;

    assign i_req   = iddr_read;
    assign d_req   = dddr_read | dddr_write;
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
    // A real response in the expiry cycle takes precedence over the abort.
    assign timeout = WDOG_EN && serving && !pmem_resp && (wdog_q == WDOG_LAST);
    assign done    = serving && (pmem_resp || timeout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            read_q   <= read_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        wdog_d   = '0;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        read_d   = read_q;
        write_d  = write_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || (streak_q < STREAK_MAX))) begin
                    state_d = SERVE_D;
                    addr_d  = dddr_addr;
                    wdata_d = dddr_wdata;
                    read_d  = dddr_read;
                    write_d = dddr_write;
                    // The grant condition keeps the streak below its ceiling here.
                    streak_d = i_req ? streak_q + 1'b1 : '0;
                end else if (i_req) begin
                    state_d  = SERVE_I;
                    addr_d   = iddr_addr;
                    read_d   = 1'b1;
                    write_d  = 1'b0;
                    streak_d = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iddr_resp  = done && (state_q == SERVE_I);
        dddr_resp  = done && (state_q == SERVE_D);
        iddr_rdata = (timeout && (state_q == SERVE_I)) ? '0 : pmem_rdata;
        dddr_rdata = (timeout && (state_q == SERVE_D)) ? '0 : pmem_rdata;
    end

    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;
    assign pmem_read  = read_q;
    assign pmem_write = write_q;
    assign arb_err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, hand sequences for streak/timeout/reset/illegal cases,
// then randomized requesters and memory checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int DW  = 32;
    localparam int DSM = 4;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] iddr_addr, iddr_rdata, dddr_addr, dddr_wdata, dddr_rdata;
    logic [DW-1:0] pmem_addr, pmem_wdata, pmem_rdata;
    logic          iddr_read, iddr_resp, dddr_read, dddr_write, dddr_resp;
    logic          pmem_read, pmem_write, pmem_resp, arb_err;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(.DATA_W(DW), .D_STREAK_MAX(DSM), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .iddr_addr(iddr_addr), .iddr_read(iddr_read), .iddr_rdata(iddr_rdata), .iddr_resp(iddr_resp),
        .dddr_addr(dddr_addr), .dddr_read(dddr_read), .dddr_write(dddr_write),
        .dddr_wdata(dddr_wdata), .dddr_rdata(dddr_rdata), .dddr_resp(dddr_resp),
        .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global time limit reached: n_chk=%0d", n_chk);
        $fatal(1, "time limit");
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dddr_read === 1'b1 && dddr_write === 1'b1)
            $display("warning: illegal d-port request, read and write both high at t=%0t", $time);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iddr_read = 1'b0; iddr_addr = '0;
        dddr_read = 1'b0; dddr_write = 1'b0; dddr_addr = '0; dddr_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    typedef struct {
        logic          i_rd;
        logic [DW-1:0] i_addr;
        logic          d_rd, d_wr;
        logic [DW-1:0] d_addr, d_wdata;
        logic          p_resp;
        logic [DW-1:0] p_rdata;
        logic          e_rd, e_wr;
        logic [DW-1:0] e_addr, e_wdata;
        logic          e_iresp, e_dresp, e_err;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    // reference model state for the random phase
    int            m_gnt;      // 0 none, 1 fetch, 2 data
    int            m_dwait;    // data grants given in a row while fetch waited
    int            m_start;    // cycle number of the first serve cycle
    int            tcyc;
    bit            m_err, m_rd, m_wr;
    logic [DW-1:0] m_addr, m_wdata, e_rdata;
    bit            e_to, e_done, i_act, d_act, d_wop;

    string order;
    bit    got_i, got_d, got;
    int    hi;

    initial begin
        //            i_rd  i_addr        d_rd  d_wr  d_addr       d_wdata        p_resp p_rdata        e_rd  e_wr  e_addr       e_wdata        ires  dres  err
        tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 32'h100,     32'h0,         1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 32'h55,        1'b0, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'h200,      1'b0, 1'b1, 32'h40,      32'h12345678,  1'b0, 32'h0,         1'b0, 1'b0, 32'h100,     32'h0,         1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h200,      1'b0, 1'b1, 32'h40,      32'h12345678,  1'b0, 32'h0,         1'b0, 1'b1, 32'h40,      32'h12345678,  1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'h200,      1'b0, 1'b1, 32'h40,      32'h12345678,  1'b1, 32'hA5A5A5A5,  1'b0, 1'b1, 32'h40,      32'h12345678,  1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'h200,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h40,      32'h12345678,  1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h200,      1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h200,     32'h12345678,  1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 32'h200,      1'b0, 1'b0, 32'h0,       32'h0,         1'b1, 32'hCAFEF00D,  1'b1, 1'b0, 32'h200,     32'h12345678,  1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h200,     32'h12345678,  1'b0, 1'b0, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;

        // ---------------- directed cycle table ----------------
        for (int k = 0; k < NV; k++) begin
            iddr_read = tbl[k].i_rd;  iddr_addr = tbl[k].i_addr;
            dddr_read = tbl[k].d_rd;  dddr_write = tbl[k].d_wr;
            dddr_addr = tbl[k].d_addr; dddr_wdata = tbl[k].d_wdata;
            pmem_resp = tbl[k].p_resp; pmem_rdata = tbl[k].p_rdata;
            #2;
            chk($sformatf("tbl[%0d] pmem_read", k),  pmem_read,  tbl[k].e_rd);
            chk($sformatf("tbl[%0d] pmem_write", k), pmem_write, tbl[k].e_wr);
            chk($sformatf("tbl[%0d] pmem_addr", k),  pmem_addr,  tbl[k].e_addr);
            chk($sformatf("tbl[%0d] pmem_wdata", k), pmem_wdata, tbl[k].e_wdata);
            chk($sformatf("tbl[%0d] iddr_resp", k),  iddr_resp,  tbl[k].e_iresp);
            chk($sformatf("tbl[%0d] dddr_resp", k),  dddr_resp,  tbl[k].e_dresp);
            chk($sformatf("tbl[%0d] arb_err", k),    arb_err,    tbl[k].e_err);
            if (tbl[k].e_iresp) chk($sformatf("tbl[%0d] iddr_rdata", k), iddr_rdata, tbl[k].p_rdata);
            if (tbl[k].e_dresp) chk($sformatf("tbl[%0d] dddr_rdata", k), dddr_rdata, tbl[k].p_rdata);
            cycle();
        end

        // ---------------- starvation guard: D D D D I D ----------------
        idle_inputs();
        iddr_read = 1'b1; iddr_addr = 32'h300;
        dddr_read = 1'b1; dddr_addr = 32'h1000;
        order = "";
        for (int c = 0; c < 40 && order.len() < 6; c++) begin
            pmem_resp  = pmem_read | pmem_write;
            pmem_rdata = 32'(c);
            #2;
            got_i = iddr_resp;
            got_d = dddr_resp;
            if (got_i) begin
                order = {order, "I"};
                chk("streak fetch addr", pmem_addr, 32'h300);
            end
            if (got_d) begin
                order = {order, "D"};
                chk("streak data addr", pmem_addr, dddr_addr);
            end
            cycle();
            if (got_i) iddr_read = 1'b0;
            if (got_d) dddr_addr = dddr_addr + 32'h4;
        end
        idle_inputs();
        n_chk++;
        if (order == "DDDDID") n_pass++;
        else $display("FAIL streak grant order: got '%s', expected 'DDDDID'", order);
        cycle();

        // ---------------- watchdog timeout ----------------
        #2 chk("arb_err before timeout", arb_err, 1'b0);
        cycle();
        dddr_read = 1'b1; dddr_addr = 32'h500;
        cycle();
        hi = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            pmem_rdata = 32'h77777777;
            #2;
            if (pmem_read) hi++;
            if (dddr_resp) begin
                got = 1'b1;
                chk("timeout dddr_rdata", dddr_rdata, 32'h0);
                chk("timeout strobe cycles", 32'(hi), 32'(TO));
                chk("timeout no iddr_resp", iddr_resp, 1'b0);
            end
            cycle();
        end
        chk("timeout resp seen", got, 1'b1);
        dddr_read = 1'b0;
        #2;
        chk("timeout strobe cleared", pmem_read, 1'b0);
        chk("arb_err set", arb_err, 1'b1);
        cycle();
        iddr_read = 1'b1; iddr_addr = 32'h600;
        cycle();
        #2;
        chk("post-timeout pmem_read", pmem_read, 1'b1);
        chk("post-timeout pmem_addr", pmem_addr, 32'h600);
        pmem_resp = 1'b1; pmem_rdata = 32'h00600600;
        #1;
        chk("post-timeout iddr_resp", iddr_resp, 1'b1);
        chk("post-timeout iddr_rdata", iddr_rdata, 32'h00600600);
        cycle();
        idle_inputs();
        #2 chk("arb_err sticky", arb_err, 1'b1);
        cycle();

        // ---------------- reset during SERVE_D ----------------
        dddr_read = 1'b1; dddr_addr = 32'h700;
        cycle();
        #2 chk("pre-reset pmem_read", pmem_read, 1'b1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; dddr_read = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = 32'h99;
        #2;
        chk("reset pmem_read", pmem_read, 1'b0);
        chk("reset pmem_write", pmem_write, 1'b0);
        chk("reset pmem_addr", pmem_addr, 32'h0);
        chk("reset dddr_resp", dddr_resp, 1'b0);
        chk("reset iddr_resp", iddr_resp, 1'b0);
        chk("reset arb_err", arb_err, 1'b0);
        cycle();
        idle_inputs();
        cycle();

        // ---------------- illegal read+write: both strobes pass through ----------------
        dddr_read = 1'b1; dddr_write = 1'b1; dddr_addr = 32'h800; dddr_wdata = 32'hABCD;
        cycle();
        #2;
        chk("illegal pmem_read", pmem_read, 1'b1);
        chk("illegal pmem_write", pmem_write, 1'b1);
        chk("illegal pmem_wdata", pmem_wdata, 32'hABCD);
        pmem_resp = 1'b1;
        #1 chk("illegal dddr_resp", dddr_resp, 1'b1);
        cycle();
        idle_inputs();
        cycle();

        // ---------------- randomized traffic against the reference model ----------------
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        m_gnt = 0; m_dwait = 0; m_start = 0; tcyc = 0;
        m_err = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        i_act = 1'b0; d_act = 1'b0; d_wop = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_act && m_gnt != 1 && $urandom_range(0, 2) == 0) begin
                i_act = 1'b1; iddr_addr = $urandom;
            end
            if (i_act && m_gnt == 1 && $urandom_range(0, 15) == 0) i_act = 1'b0;
            if (!d_act && m_gnt != 2 && $urandom_range(0, 1) == 0) begin
                d_act = 1'b1; d_wop = 1'($urandom_range(0, 1));
                dddr_addr = $urandom; dddr_wdata = $urandom;
            end
            if (d_act && m_gnt == 2 && $urandom_range(0, 15) == 0) d_act = 1'b0;
            iddr_read  = i_act;
            dddr_read  = d_act && !d_wop;
            dddr_write = d_act && d_wop;
            pmem_resp  = ($urandom_range(0, 3) == 0);
            pmem_rdata = $urandom;
            #2;
            e_to    = (m_gnt != 0) && !pmem_resp && (tcyc - m_start == TO - 1);
            e_done  = (m_gnt != 0) && (pmem_resp || e_to);
            e_rdata = e_to ? 32'h0 : pmem_rdata;
            chk("rnd pmem_read",  pmem_read,  m_rd);
            chk("rnd pmem_write", pmem_write, m_wr);
            chk("rnd pmem_addr",  pmem_addr,  m_addr);
            chk("rnd pmem_wdata", pmem_wdata, m_wdata);
            chk("rnd iddr_resp",  iddr_resp,  e_done && m_gnt == 1);
            chk("rnd dddr_resp",  dddr_resp,  e_done && m_gnt == 2);
            chk("rnd arb_err",    arb_err,    m_err);
            if (e_done && m_gnt == 1) begin
                chk("rnd iddr_rdata", iddr_rdata, e_rdata);
                i_act = 1'b0;
            end
            if (e_done && m_gnt == 2) begin
                chk("rnd dddr_rdata", dddr_rdata, e_rdata);
                d_act = 1'b0;
            end
            @(posedge clk);
            if (m_gnt == 0) begin
                if ((dddr_read || dddr_write) && (!iddr_read || m_dwait < DSM)) begin
                    m_gnt = 2; m_addr = dddr_addr; m_wdata = dddr_wdata;
                    m_rd = dddr_read; m_wr = dddr_write;
                    m_dwait = iddr_read ? m_dwait + 1 : 0;
                    m_start = tcyc + 1;
                end else if (iddr_read) begin
                    m_gnt = 1; m_addr = iddr_addr; m_rd = 1'b1; m_wr = 1'b0;
                    m_dwait = 0;
                    m_start = tcyc + 1;
                end
            end else if (e_done) begin
                m_gnt = 0; m_rd = 1'b0; m_wr = 1'b0;
                if (e_to) m_err = 1'b1;
            end
            tcyc++;
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
